// File: rtl/div_mon_pkg.sv
// Shared widths, FSM state type and saturating-add helper for the divider
// error monitor.
package div_mon_pkg;

    localparam int N_W   = 16;
    localparam int D_W   = 8;
    localparam int Q_W   = 8;
    localparam int ERR_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        ACC  = 2'd2
    } div_mon_state_t;

    // The sum is clipped to the all-ones value of a w-bit field.
    // hit reports that clipping happened. Callers cast the result down to w bits.
    function automatic logic [63:0] sat_add(
        input  logic [63:0] a,
        input  logic [63:0] b,
        input  int unsigned w,
        output logic        hit
    );
        logic [64:0] s;
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        s     = {1'b0, a} + {1'b0, b};
        hit   = (s > {1'b0, max_v});
        return hit ? max_v : s[63:0];
    endfunction

endpackage

// File: rtl/seq_restoring_div.sv
// Iterative restoring divider computing 16/8 -> 8-bit quotient/remainder,
// one quotient bit per cycle after a start pulse.
module seq_restoring_div
    import div_mon_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [D_W-1:0] d,
    output logic           done,
    output logic [Q_W-1:0] q,
    output logic [D_W-1:0] rem
);

    logic [7:0]     n_lo;
    logic [D_W-1:0] d_reg;
    logic [2:0]     idx;
    logic           busy;
    logic [D_W:0]   t;
    logic [D_W:0]   diff;

    assign t    = {rem, n_lo[idx]};
    assign diff = t - {1'b0, d_reg};
    // High during the cycle whose closing edge performs the final step.
    assign done = busy && (idx == 3'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_lo  <= '0;
            d_reg <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            q     <= '0;
            rem   <= '0;
        end else if (start) begin
            n_lo  <= n[7:0];
            d_reg <= d;
            rem   <= n[15:8];
            idx   <= 3'd7;
            q     <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            // With d = 0 every step subtracts, giving q = 0xFF and rem = n[7:0].
            if (t >= {1'b0, d_reg}) begin
                q[idx] <= 1'b1;
                rem    <= diff[D_W-1:0];
            end else begin
                rem    <= t[D_W-1:0];
            end
            idx <= idx - 3'd1;
            if (idx == 3'd0)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/div_mse_monitor.sv
// Compares the approximate divider output against an exact sequential
// divider and accumulates squared-error, max-error and mismatch statistics.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// DIV   | restoring divider stepping through 8 quotient bits
// ACC   | error/square computed, results and statistics updated
module div_mse_monitor
    import div_mon_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_W-1:0]          n,
    input  logic [D_W-1:0]          d,
    input  logic [Q_W-1:0]          q_apx,
    input  logic [D_W-1:0]          r_apx,
    input  logic                    clear,
    output logic                    out_valid,
    output logic [Q_W-1:0]          q_exact,
    output logic [D_W-1:0]          r_exact,
    output logic signed [ERR_W-1:0] err,
    output logic                    r_mismatch,
    output logic [ACC_W-1:0]        sq_err_sum,
    output logic [Q_W-1:0]          max_abs_err,
    output logic [CNT_W-1:0]        sample_cnt,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic                    sat
);

    div_mon_state_t         state;
    logic [Q_W-1:0]         q_apx_r;
    logic [D_W-1:0]         r_apx_r;
    logic                   start;
    logic                   div_done;
    logic [Q_W-1:0]         div_q;
    logic [D_W-1:0]         div_rem;

    logic signed [ERR_W-1:0] err_c;
    logic [Q_W-1:0]          abs_c;
    logic [15:0]             sq_c;
    logic [ACC_W-1:0]        sq_next;
    logic [CNT_W-1:0]        cnt_next;
    logic [CNT_W-1:0]        mis_next;
    logic                    sq_hit;
    logic                    cnt_hit;
    logic                    mis_hit;

    assign start = (state == IDLE) && in_valid;

    seq_restoring_div u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .n     (n),
        .d     (d),
        .done  (div_done),
        .q     (div_q),
        .rem   (div_rem)
    );

    always_comb begin
        err_c    = {1'b0, div_q} - {1'b0, q_apx_r};
        abs_c    = err_c[ERR_W-1] ? Q_W'(-err_c) : Q_W'(err_c);
        sq_c     = {8'd0, abs_c} * {8'd0, abs_c};
        sq_next  = ACC_W'(sat_add(64'(sq_err_sum), 64'(sq_c), ACC_W, sq_hit));
        cnt_next = CNT_W'(sat_add(64'(sample_cnt), 64'd1, CNT_W, cnt_hit));
        mis_next = CNT_W'(sat_add(64'(mismatch_cnt), (err_c != '0) ? 64'd1 : 64'd0,
                                  CNT_W, mis_hit));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            q_apx_r      <= '0;
            r_apx_r      <= '0;
            out_valid    <= 1'b0;
            q_exact      <= '0;
            r_exact      <= '0;
            err          <= '0;
            r_mismatch   <= 1'b0;
            sq_err_sum   <= '0;
            max_abs_err  <= '0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            sat          <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= DIV;
                        in_ready <= 1'b0;
                        q_apx_r  <= q_apx;
                        r_apx_r  <= r_apx;
                    end
                end
                DIV: begin
                    if (div_done)
                        state <= ACC;
                end
                ACC: begin
                    state        <= IDLE;
                    in_ready     <= 1'b1;
                    out_valid    <= 1'b1;
                    q_exact      <= div_q;
                    r_exact      <= div_rem;
                    err          <= err_c;
                    r_mismatch   <= (r_apx_r != div_rem);
                    sq_err_sum   <= sq_next;
                    sample_cnt   <= cnt_next;
                    mismatch_cnt <= mis_next;
                    if (abs_c > max_abs_err)
                        max_abs_err <= abs_c;
                    sat <= sat | sq_hit | cnt_hit | mis_hit;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
            // Clear overrides any accumulation happening on the same edge.
            if (clear) begin
                sq_err_sum   <= '0;
                max_abs_err  <= '0;
                sample_cnt   <= '0;
                mismatch_cnt <= '0;
                sat          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_mse_monitor.sv
// Self-checking bench for div_mse_monitor: scoreboard of expected results,
// running statistics model, latency/handshake, clear and reset checks.
module tb_div_mse_monitor;

    localparam int ACC_W = 32;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       n;
    logic [7:0]        d;
    logic [7:0]        q_apx;
    logic [7:0]        r_apx;
    logic              clear;
    logic              out_valid;
    logic [7:0]        q_exact;
    logic [7:0]        r_exact;
    logic signed [8:0] err;
    logic              r_mismatch;
    logic [ACC_W-1:0]  sq_err_sum;
    logic [7:0]        max_abs_err;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic              sat;

    always #5 clk = ~clk;

    div_mse_monitor #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .n            (n),
        .d            (d),
        .q_apx        (q_apx),
        .r_apx        (r_apx),
        .clear        (clear),
        .out_valid    (out_valid),
        .q_exact      (q_exact),
        .r_exact      (r_exact),
        .err          (err),
        .r_mismatch   (r_mismatch),
        .sq_err_sum   (sq_err_sum),
        .max_abs_err  (max_abs_err),
        .sample_cnt   (sample_cnt),
        .mismatch_cnt (mismatch_cnt),
        .sat          (sat)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic [8:0] e;
        int         a;
        logic       m;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    longint m_sq;
    int     m_max, m_cnt, m_mis;

    task automatic push_exp(input logic [7:0] eq, input logic [7:0] er,
                            input logic [7:0] qa, input logic [7:0] ra);
        exp_t x;
        int   ev;
        ev  = int'(eq) - int'(qa);
        x.q = eq;
        x.r = er;
        x.e = 9'(ev);
        x.a = (ev < 0) ? -ev : ev;
        x.m = (ra != er);
        sb.push_back(x);
    endtask

    task automatic model_acc(input exp_t x);
        m_sq = m_sq + longint'(x.a * x.a);
        if (m_sq > 64'hFFFF_FFFF) m_sq = 64'hFFFF_FFFF;
        if (x.a > m_max) m_max = x.a;
        if (m_cnt < 65535) m_cnt++;
        if (x.a != 0 && m_mis < 65535) m_mis++;
    endtask

    task automatic model_zero();
        m_sq = 0; m_max = 0; m_cnt = 0; m_mis = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        n = '0; d = '0; q_apx = '0; r_apx = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_zero();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if ({out_valid, q_exact, r_exact, err, r_mismatch, sq_err_sum, max_abs_err,
             sample_cnt, mismatch_cnt, sat} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b q=%0d r=%0d err=%0d sq=%0d max=%0d cnt=%0d mis=%0d sat=%b expected all 0",
                     out_valid, q_exact, r_exact, err, sq_err_sum, max_abs_err,
                     sample_cnt, mismatch_cnt, sat);
        end
    endtask

    task automatic test_samples();
        logic [15:0] tn[9];
        logic [7:0]  td[9], tqa[9], tra[9], teq[9], ter[9];
        exp_t        x;
        int          lat;
        tn[0] = 16'd100;   td[0] = 8'd7;  tqa[0] = 8'd14;  tra[0] = 8'd2; teq[0] = 8'd14;  ter[0] = 8'd2;
        tn[1] = 16'd1000;  td[1] = 8'd10; tqa[1] = 8'd96;  tra[1] = 8'd0; teq[1] = 8'd100; ter[1] = 8'd0;
        tn[2] = 16'h1234;  td[2] = 8'd0;  tqa[2] = 8'd0;   tra[2] = 8'd0; teq[2] = 8'hFF;  ter[2] = 8'h34;
        tn[3] = 16'h0A00;  td[3] = 8'd3;  tqa[3] = 8'd255; tra[3] = 8'd3; teq[3] = 8'd255; ter[3] = 8'd3;
        tn[4] = 16'd200;   td[4] = 8'd9;  tqa[4] = 8'd25;  tra[4] = 8'd2; teq[4] = 8'd22;  ter[4] = 8'd2;
        for (int i = 5; i < 9; i++) begin
            td[i]  = 8'($urandom_range(1, 255));
            tn[i]  = 16'($urandom_range(0, int'(td[i]) * 256 - 1));
            teq[i] = 8'(tn[i] / {8'd0, td[i]});
            ter[i] = 8'(tn[i] % {8'd0, td[i]});
            tqa[i] = teq[i] ^ 8'($urandom_range(0, 3));
            tra[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < 9; i++) begin
            n = tn[i]; d = td[i]; q_apx = tqa[i]; r_apx = tra[i]; in_valid = 1'b1;
            push_exp(teq[i], ter[i], tqa[i], tra[i]);
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 0;
            for (int k = 1; k <= 15 && lat == 0; k++) begin
                @(negedge clk);
                if (out_valid === 1'b1) lat = k;
            end
            checks++;
            if (lat != 10) begin
                errors++; $display("FAIL latency[%0d]: got %0d cycles expected 10", i, lat);
            end
            if (lat == 0) begin
                sb.delete();
            end else begin
                x = sb.pop_front();
                model_acc(x);
                checks++;
                if (q_exact !== x.q) begin
                    errors++; $display("FAIL q_exact[%0d]: got %0d expected %0d", i, q_exact, x.q);
                end
                checks++;
                if (r_exact !== x.r) begin
                    errors++; $display("FAIL r_exact[%0d]: got %0d expected %0d", i, r_exact, x.r);
                end
                checks++;
                if (err !== x.e) begin
                    errors++; $display("FAIL err[%0d]: got %h expected %h", i, err, x.e);
                end
                checks++;
                if (r_mismatch !== x.m) begin
                    errors++; $display("FAIL r_mismatch[%0d]: got %b expected %b", i, r_mismatch, x.m);
                end
                checks++;
                if (sq_err_sum !== ACC_W'(m_sq)) begin
                    errors++; $display("FAIL sq_err_sum[%0d]: got %0d expected %0d", i, sq_err_sum, m_sq);
                end
                checks++;
                if (max_abs_err !== 8'(m_max)) begin
                    errors++; $display("FAIL max_abs_err[%0d]: got %0d expected %0d", i, max_abs_err, m_max);
                end
                checks++;
                if (sample_cnt !== CNT_W'(m_cnt) || mismatch_cnt !== CNT_W'(m_mis)) begin
                    errors++;
                    $display("FAIL counts[%0d]: got cnt=%0d mis=%0d expected cnt=%0d mis=%0d",
                             i, sample_cnt, mismatch_cnt, m_cnt, m_mis);
                end
                checks++;
                if (sat !== 1'b0) begin
                    errors++; $display("FAIL sat[%0d]: got %b expected 0", i, sat);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        logic exp_hs;
        n = 16'd300; d = 8'd12; q_apx = 8'd25; r_apx = 8'd0; in_valid = 1'b1;
        push_exp(8'd25, 8'd0, 8'd25, 8'd0);
        @(posedge clk);
        #1;
        n = 16'd77; d = 8'd8; q_apx = 8'd8; r_apx = 8'd5;
        push_exp(8'd9, 8'd5, 8'd8, 8'd5);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_hs = (k == 10) || (k == 20);
            checks++;
            if (in_ready !== exp_hs) begin
                errors++; $display("FAIL b2b_in_ready@%0d: got %b expected %b", k, in_ready, exp_hs);
            end
            checks++;
            if (out_valid !== exp_hs) begin
                errors++; $display("FAIL b2b_out_valid@%0d: got %b expected %b", k, out_valid, exp_hs);
            end
            if (out_valid === 1'b1 && sb.size() > 0) begin
                x = sb.pop_front();
                model_acc(x);
                checks++;
                if (q_exact !== x.q || r_exact !== x.r || err !== x.e) begin
                    errors++;
                    $display("FAIL b2b_result@%0d: got q=%0d r=%0d err=%h expected q=%0d r=%0d err=%h",
                             k, q_exact, r_exact, err, x.q, x.r, x.e);
                end
                checks++;
                if (sq_err_sum !== ACC_W'(m_sq) || sample_cnt !== CNT_W'(m_cnt)) begin
                    errors++;
                    $display("FAIL b2b_stats@%0d: got sq=%0d cnt=%0d expected sq=%0d cnt=%0d",
                             k, sq_err_sum, sample_cnt, m_sq, m_cnt);
                end
            end
            if (k == 11) in_valid = 1'b0;
        end
        sb.delete();
    endtask

    task automatic test_clear();
        int seen;
        // Clear on the ACC edge: result still reported, statistics zeroed.
        n = 16'd50; d = 8'd5; q_apx = 8'd7; r_apx = 8'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_zero();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 9) clear = 1'b1;
            if (k == 10) begin
                clear = 1'b0;
                checks++;
                if (out_valid !== 1'b1 || err !== 9'sd3 || q_exact !== 8'd10) begin
                    errors++;
                    $display("FAIL clear_acc_result: got ov=%b err=%0d q=%0d expected ov=1 err=3 q=10",
                             out_valid, err, q_exact);
                end
                checks++;
                if ({sq_err_sum, max_abs_err, sample_cnt, mismatch_cnt, sat} !== '0) begin
                    errors++;
                    $display("FAIL clear_acc_stats: got sq=%0d max=%0d cnt=%0d mis=%0d sat=%b expected all 0",
                             sq_err_sum, max_abs_err, sample_cnt, mismatch_cnt, sat);
                end
            end
        end
        // Clear during DIV: the in-flight sample is still accumulated.
        n = 16'd100; d = 8'd7; q_apx = 8'd12; r_apx = 8'd2; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 0;
        for (int k = 1; k <= 15 && seen == 0; k++) begin
            @(negedge clk);
            if (k == 3) clear = 1'b1;
            if (k == 4) clear = 1'b0;
            if (out_valid === 1'b1) seen = k;
        end
        checks++;
        if (seen != 10) begin
            errors++; $display("FAIL clear_div_latency: got %0d expected 10", seen);
        end
        checks++;
        if (sq_err_sum !== 32'd4 || max_abs_err !== 8'd2 || sample_cnt !== 16'd1 ||
            mismatch_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clear_div_stats: got sq=%0d max=%0d cnt=%0d mis=%0d expected sq=4 max=2 cnt=1 mis=1",
                     sq_err_sum, max_abs_err, sample_cnt, mismatch_cnt);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        n = 16'd1000; d = 8'd10; q_apx = 8'd90; r_apx = 8'd1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) rst_n = 1'b0;
            if (k == 5) rst_n = 1'b1;
        end
        model_zero();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if ({out_valid, q_exact, r_exact, err, r_mismatch, sq_err_sum, max_abs_err,
             sample_cnt, mismatch_cnt, sat} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got ov=%b q=%0d err=%0d sq=%0d cnt=%0d expected all 0",
                     out_valid, q_exact, err, sq_err_sum, sample_cnt);
        end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL abort_no_out_valid: got %0d pulses expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_samples();
        test_back_to_back();
        test_clear();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
